// File: rtl/parking_gate_ctrl_if.sv
`default_nettype none
// ==========================================================================
// parking_gate_ctrl_if - lane sensors, motor drives and count pulses. rev 1.0
// ==========================================================================
interface parking_gate_ctrl_if;
  logic full;
  logic en_loop;
  logic en_beam;
  logic ex_loop;
  logic ex_beam;
  logic car_in;
  logic car_out;
  logic en_mot_open;
  logic en_mot_close;
  logic ex_mot_open;
  logic ex_mot_close;
  logic en_gate_up;
  logic ex_gate_up;
  logic en_denied;

  modport master (
    output full, en_loop, en_beam, ex_loop, ex_beam,
    input  car_in, car_out, en_mot_open, en_mot_close, ex_mot_open,
           ex_mot_close, en_gate_up, ex_gate_up, en_denied
  );

  modport slave (
    input  full, en_loop, en_beam, ex_loop, ex_beam,
    output car_in, car_out, en_mot_open, en_mot_close, ex_mot_open,
           ex_mot_close, en_gate_up, ex_gate_up, en_denied
  );
endinterface
`default_nettype wire

// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ==========================================================================
// parking_gate_ctrl - debounced two-lane barrier sequencer with count arbiter. rev 1.0
// ==========================================================================
module parking_gate_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int OPEN_CYCLES  = 8,
  parameter int CLOSE_CYCLES = 8,
  parameter int PASS_TIMEOUT = 64,
  parameter int TW           = 16
) (
  input  logic                clk,
  input  logic                reset,
  parking_gate_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OPENING   = 3'd1,
    S_WAIT_PASS = 3'd2,
    S_PASSING   = 3'd3,
    S_CLOSING   = 3'd4
  } state_t;

  localparam int            CW        = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] C_OPEN    = TW'(OPEN_CYCLES);
  localparam logic [TW-1:0] C_CLOSE   = TW'(CLOSE_CYCLES);
  localparam logic [TW-1:0] C_PASS    = TW'(PASS_TIMEOUT);
  localparam logic [TW-1:0] C_ONE     = TW'(1);

  // Sensor order: 0 en_loop, 1 en_beam, 2 ex_loop, 3 ex_beam
  logic [3:0] raw;
  logic [3:0] filt;
  assign raw = {bus.ex_beam, bus.ex_loop, bus.en_beam, bus.en_loop};

  for (genvar i = 0; i < 4; i++) begin : g_filt
    logic [CW-1:0] cnt;
    logic          val;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        val <= 1'b0;
      end else if (raw[i] == val) begin
        cnt <= '0;
      end else if (cnt == C_DB_LAST) begin
        cnt <= '0;
        val <= raw[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign filt[i] = val;
  end

  logic [1:0] loop_f;
  logic [1:0] beam_f;
  logic [1:0] permit;
  assign loop_f = {filt[2], filt[0]};
  assign beam_f = {filt[3], filt[1]};
  // Only the entry lane is gated by the occupancy flag
  assign permit = {1'b1, ~bus.full};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          counted;
    logic          counted_nxt;
    logic          req_q;
    logic          req_nxt;
    logic          expire;
    logic          is_idle;
    logic          mot_open;
    logic          mot_close;
    logic          gate_up;

    assign expire = (timer == C_ONE);

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= S_IDLE;
        timer   <= '0;
        counted <= 1'b0;
        req_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        timer   <= timer_nxt;
        counted <= counted_nxt;
        req_q   <= req_nxt;
      end
    end

    // counted keeps a reversed car from being counted on each beam clear
    always_comb begin
      state_nxt   = state;
      timer_nxt   = (timer != '0) ? timer - 1'b1 : timer;
      counted_nxt = counted;
      req_nxt     = 1'b0;
      case (state)
        S_IDLE: begin
          counted_nxt = 1'b0;
          if (loop_f[l] && permit[l]) begin
            state_nxt = S_OPENING;
            timer_nxt = C_OPEN;
          end
        end
        S_OPENING: begin
          if (expire) begin
            state_nxt = S_WAIT_PASS;
            timer_nxt = C_PASS;
          end
        end
        S_WAIT_PASS: begin
          if (beam_f[l]) begin
            state_nxt = S_PASSING;
            timer_nxt = '0;
          end else if (expire) begin
            state_nxt = S_CLOSING;
            timer_nxt = C_CLOSE;
          end
        end
        S_PASSING: begin
          if (!beam_f[l]) begin
            state_nxt   = S_CLOSING;
            timer_nxt   = C_CLOSE;
            req_nxt     = !counted;
            counted_nxt = 1'b1;
          end
        end
        S_CLOSING: begin
          if (beam_f[l]) begin
            state_nxt = S_OPENING;
            timer_nxt = C_OPEN;
          end else if (expire) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end
      endcase
    end

    assign is_idle   = (state == S_IDLE);
    assign mot_open  = (state == S_OPENING);
    assign mot_close = (state == S_CLOSING);
    assign gate_up   = (state == S_WAIT_PASS) || (state == S_PASSING);
  end

  logic req_en;
  logic req_ex;
  assign req_en = g_lane[0].req_q;
  assign req_ex = g_lane[1].req_q;

  logic denied_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      denied_q <= 1'b0;
    end else begin
      denied_q <= g_lane[0].is_idle && loop_f[0] && bus.full;
    end
  end

  // Exit always wins; a deferred entry waits in pend until no exit request
  logic car_in_q;
  logic car_out_q;
  logic pend;
  always_ff @(posedge clk) begin
    if (reset) begin
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      pend      <= 1'b0;
    end else begin
      car_out_q <= req_ex;
      if (req_ex) begin
        car_in_q <= 1'b0;
        pend     <= pend | req_en;
      end else begin
        car_in_q <= pend | req_en;
        pend     <= pend & req_en;
      end
    end
  end

  assign bus.car_in       = car_in_q;
  assign bus.car_out      = car_out_q;
  assign bus.en_denied    = denied_q;
  assign bus.en_mot_open  = g_lane[0].mot_open;
  assign bus.en_mot_close = g_lane[0].mot_close;
  assign bus.en_gate_up   = g_lane[0].gate_up;
  assign bus.ex_mot_open  = g_lane[1].mot_open;
  assign bus.ex_mot_close = g_lane[1].mot_close;
  assign bus.ex_gate_up   = g_lane[1].gate_up;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_parking_gate_ctrl - directed scenarios for the two-lane gate controller. rev 1.0
// ==========================================================================
module tb_parking_gate_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  int n_in, n_out, n_eo, n_ec, n_eu, n_xo, n_xc, n_xu, n_both;

  parking_gate_ctrl_if bus();

  parking_gate_ctrl #(
    .DEBOUNCE(4), .OPEN_CYCLES(8), .CLOSE_CYCLES(8), .PASS_TIMEOUT(64), .TW(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {bus.car_in, bus.car_out, bus.en_mot_open, bus.en_mot_close,
            bus.ex_mot_open, bus.ex_mot_close, bus.en_gate_up,
            bus.ex_gate_up, bus.en_denied};
  endfunction

  task automatic clear_counts();
    n_in = 0; n_out = 0; n_eo = 0; n_ec = 0; n_eu = 0;
    n_xo = 0; n_xc = 0; n_xu = 0; n_both = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.car_in)       n_in++;
      if (bus.car_out)      n_out++;
      if (bus.en_mot_open)  n_eo++;
      if (bus.en_mot_close) n_ec++;
      if (bus.en_gate_up)   n_eu++;
      if (bus.ex_mot_open)  n_xo++;
      if (bus.ex_mot_close) n_xc++;
      if (bus.ex_gate_up)   n_xu++;
      if (bus.car_in && bus.car_out) n_both++;
      if (bus.en_mot_open && bus.en_mot_close) n_both++;
      if (bus.ex_mot_open && bus.ex_mot_close) n_both++;
    end
  endtask

  task automatic test_reset();
    bus.full = 1'b0; bus.en_loop = 1'b0; bus.en_beam = 1'b0;
    bus.ex_loop = 1'b0; bus.ex_beam = 1'b0;
    reset = 1'b1;
    run(3);
    n_checks++;
    if (outs() !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", outs(), 9'd0);
    end
    reset = 1'b0;
    run(2);
    n_checks++;
    if (outs() !== 9'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected %b", outs(), 9'd0);
    end
  endtask

  task automatic test_entry_pass();
    clear_counts();
    bus.en_loop = 1'b1;
    run(4);
    n_checks++;
    if (n_eo !== 0) begin
      n_fail++; $display("FAIL entry_open_early: got %0d expected 0", n_eo);
    end
    run(1);
    n_checks++;
    if (bus.en_mot_open !== 1'b1) begin
      n_fail++; $display("FAIL entry_open_latency: got %b expected 1", bus.en_mot_open);
    end
    run(5);
    bus.en_loop = 1'b0;
    bus.en_beam = 1'b1;
    run(6);
    bus.en_beam = 1'b0;
    run(4);
    n_checks++;
    if (bus.en_gate_up !== 1'b1) begin
      n_fail++; $display("FAIL entry_passing_up: got %b expected 1", bus.en_gate_up);
    end
    run(1);
    n_checks++;
    if ({bus.en_mot_close, bus.car_in} !== 2'b10) begin
      n_fail++; $display("FAIL entry_close_start: got %b expected 10", {bus.en_mot_close, bus.car_in});
    end
    run(1);
    n_checks++;
    if (bus.car_in !== 1'b1) begin
      n_fail++; $display("FAIL entry_car_in_pulse: got %b expected 1", bus.car_in);
    end
    run(20);
    n_checks++;
    if ({n_eo, n_ec, n_eu, n_in, n_out, n_both} !== {32'd8, 32'd8, 32'd8, 32'd1, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL entry_totals: got open=%0d close=%0d up=%0d in=%0d out=%0d both=%0d expected 8 8 8 1 0 0",
                         n_eo, n_ec, n_eu, n_in, n_out, n_both);
    end
    n_checks++;
    if (outs() !== 9'd0) begin
      n_fail++; $display("FAIL entry_back_idle: got %b expected %b", outs(), 9'd0);
    end
  endtask

  task automatic test_full_refusal();
    clear_counts();
    bus.full = 1'b1;
    bus.en_loop = 1'b1;
    run(4);
    n_checks++;
    if (bus.en_denied !== 1'b0) begin
      n_fail++; $display("FAIL denied_early: got %b expected 0", bus.en_denied);
    end
    run(1);
    n_checks++;
    if (bus.en_denied !== 1'b1) begin
      n_fail++; $display("FAIL denied_set: got %b expected 1", bus.en_denied);
    end
    run(15);
    n_checks++;
    if ({bus.en_denied, 32'(n_eo), 32'(n_eu), 32'(n_in)} !== {1'b1, 32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL denied_hold: got denied=%b open=%0d up=%0d in=%0d expected 1 0 0 0",
                         bus.en_denied, n_eo, n_eu, n_in);
    end
    bus.full = 1'b0;
    run(1);
    n_checks++;
    if ({bus.en_mot_open, bus.en_denied} !== 2'b10) begin
      n_fail++; $display("FAIL full_drop_opens: got %b expected 10", {bus.en_mot_open, bus.en_denied});
    end
    bus.en_loop = 1'b0;
    run(85);
    n_checks++;
    if ({n_eo, n_ec, n_in} !== {32'd8, 32'd8, 32'd0}) begin
      n_fail++; $display("FAIL refusal_totals: got open=%0d close=%0d in=%0d expected 8 8 0", n_eo, n_ec, n_in);
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    bus.ex_loop = 1'b1;
    run(5);
    n_checks++;
    if (bus.ex_mot_open !== 1'b1) begin
      n_fail++; $display("FAIL exit_open: got %b expected 1", bus.ex_mot_open);
    end
    run(8);
    n_checks++;
    if (bus.ex_gate_up !== 1'b1) begin
      n_fail++; $display("FAIL exit_up: got %b expected 1", bus.ex_gate_up);
    end
    bus.ex_loop = 1'b0;
    run(63);
    n_checks++;
    if (bus.ex_gate_up !== 1'b1) begin
      n_fail++; $display("FAIL exit_up_last: got %b expected 1", bus.ex_gate_up);
    end
    run(1);
    n_checks++;
    if ({bus.ex_gate_up, bus.ex_mot_close} !== 2'b01) begin
      n_fail++; $display("FAIL exit_timeout_close: got %b expected 01", {bus.ex_gate_up, bus.ex_mot_close});
    end
    run(8);
    n_checks++;
    if ({n_xo, n_xu, n_xc, n_out, n_in} !== {32'd8, 32'd64, 32'd8, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL timeout_totals: got open=%0d up=%0d close=%0d out=%0d in=%0d expected 8 64 8 0 0",
                         n_xo, n_xu, n_xc, n_out, n_in);
    end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    bus.en_loop = 1'b1; bus.ex_loop = 1'b1;
    run(10);
    bus.en_loop = 1'b0; bus.ex_loop = 1'b0;
    bus.en_beam = 1'b1; bus.ex_beam = 1'b1;
    run(6);
    bus.en_beam = 1'b0; bus.ex_beam = 1'b0;
    run(6);
    n_checks++;
    if ({bus.car_out, bus.car_in} !== 2'b10) begin
      n_fail++; $display("FAIL sim_out_first: got out,in=%b expected 10", {bus.car_out, bus.car_in});
    end
    run(1);
    n_checks++;
    if ({bus.car_out, bus.car_in} !== 2'b01) begin
      n_fail++; $display("FAIL sim_in_deferred: got out,in=%b expected 01", {bus.car_out, bus.car_in});
    end
    run(18);
    n_checks++;
    if ({n_in, n_out, n_both} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL sim_totals: got in=%0d out=%0d both=%0d expected 1 1 0", n_in, n_out, n_both);
    end
  endtask

  task automatic test_reversal();
    clear_counts();
    bus.en_loop = 1'b1;
    run(13);
    bus.en_loop = 1'b0;
    run(62);
    bus.en_beam = 1'b1;
    run(2);
    n_checks++;
    if (bus.en_mot_close !== 1'b1) begin
      n_fail++; $display("FAIL rev_closing: got %b expected 1", bus.en_mot_close);
    end
    run(3);
    n_checks++;
    if ({bus.en_mot_open, bus.en_mot_close} !== 2'b10) begin
      n_fail++; $display("FAIL rev_reopen: got %b expected 10", {bus.en_mot_open, bus.en_mot_close});
    end
    run(10);
    bus.en_beam = 1'b0;
    run(5);
    n_checks++;
    if ({bus.en_mot_close, bus.car_in} !== 2'b10) begin
      n_fail++; $display("FAIL rev_final_close: got %b expected 10", {bus.en_mot_close, bus.car_in});
    end
    run(1);
    n_checks++;
    if (bus.car_in !== 1'b1) begin
      n_fail++; $display("FAIL rev_car_in: got %b expected 1", bus.car_in);
    end
    run(10);
    n_checks++;
    if ({n_eo, n_ec, n_eu, n_in, n_both} !== {32'd16, 32'd11, 32'd71, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL rev_totals: got open=%0d close=%0d up=%0d in=%0d both=%0d expected 16 11 71 1 0",
                         n_eo, n_ec, n_eu, n_in, n_both);
    end
  endtask

  task automatic test_glitch_reset();
    clear_counts();
    bus.en_loop = 1'b1;
    run(13);
    bus.en_loop = 1'b0;
    bus.en_beam = 1'b1;
    run(3);
    bus.en_beam = 1'b0;
    run(10);
    n_checks++;
    if ({bus.en_gate_up, bus.en_mot_close, 32'(n_in)} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL glitch_ignored: got up=%b close=%b in=%0d expected 1 0 0",
                         bus.en_gate_up, bus.en_mot_close, n_in);
    end
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    n_checks++;
    if (outs() !== 9'd0) begin
      n_fail++; $display("FAIL reset_wait_pass: got %b expected %b", outs(), 9'd0);
    end
    bus.en_loop = 1'b1;
    run(6);
    n_checks++;
    if (bus.en_mot_open !== 1'b1) begin
      n_fail++; $display("FAIL reopen_before_reset: got %b expected 1", bus.en_mot_open);
    end
    reset = 1'b1;
    bus.en_loop = 1'b0;
    run(1);
    n_checks++;
    if (outs() !== 9'd0) begin
      n_fail++; $display("FAIL reset_opening: got %b expected %b", outs(), 9'd0);
    end
    reset = 1'b0;
    clear_counts();
    run(30);
    n_checks++;
    if ({n_eo, n_ec, n_in, n_out} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL post_reset_quiet: got open=%0d close=%0d in=%0d out=%0d expected 0 0 0 0",
                         n_eo, n_ec, n_in, n_out);
    end
  endtask

  initial begin
    test_reset();
    test_entry_pass();
    test_full_refusal();
    test_timeout();
    test_simultaneous();
    test_reversal();
    test_glitch_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Lane controller for the car park's entry and exit barriers. It debounces the approach-loop and beam-break sensors of each lane and sequences each barrier motor through open/pass/close. It emits the single-cycle `car_in` / `car_out` pulses consumed by the occupancy counter, and uses that counter's `full` flag to refuse entry. It guarantees `car_in` and `car_out` are never high in the same cycle.

## Interface
- `DEBOUNCE`, 4: consecutive cycles a raw sensor must differ from its filtered value before the filter flips (≥1).
- `OPEN_CYCLES`, 8: cycles the open motor drive is asserted.
- `CLOSE_CYCLES`, 8: cycles the close motor drive is asserted.
- `PASS_TIMEOUT`, 64: cycles the gate waits open for the beam to break before closing.
- `TW`, 16: width of each lane timer; must hold the largest timing parameter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `full` in 1: occupancy-full flag from the counter.
- `en_loop`, `en_beam` in 1 each: raw entry-lane approach loop and beam (1 = vehicle present / beam broken).
- `ex_loop`, `ex_beam` in 1 each: raw exit-lane sensors, same meaning.
- `car_in`, `car_out` out 1 each: one-cycle count pulses.
- `en_mot_open`, `en_mot_close` out 1 each: entry motor drives.
- `ex_mot_open`, `ex_mot_close` out 1 each: exit motor drives.
- `en_gate_up`, `ex_gate_up` out 1 each: barrier fully open.
- `en_denied` out 1: entry refused because the park is full.

## Operation
- **Debounce:** one filter per raw sensor (4 total), each with a filtered register and a run counter.
  - Counter clears whenever raw equals filtered.
  - Filtered value flips on the edge at which raw has differed for `DEBOUNCE` consecutive cycles.
  - Filtered values reset to 0.
- **Lane FSM:** each lane runs an identical FSM on filtered sensors: IDLE, OPENING, WAIT_PASS, PASSING, CLOSING.
  - IDLE → OPENING: loop = 1, and for the entry lane also `full` = 0. Timer loads `OPEN_CYCLES`.
  - OPENING → WAIT_PASS: when the timer expires. Timer loads `PASS_TIMEOUT`.
  - WAIT_PASS → PASSING: beam = 1.
  - WAIT_PASS → CLOSING: timer expires with beam still 0. No count pulse is issued.
  - PASSING → CLOSING: beam returns to 0. Raises that lane's count request.
  - CLOSING → IDLE: timer (`CLOSE_CYCLES`) expires.
  - CLOSING → OPENING: beam = 1 during CLOSING (safety reversal). Timer reloads `OPEN_CYCLES`; the car is counted once only, on its final beam clear.
- **Entry refusal:** in IDLE with entry loop = 1 and `full` = 1, `en_denied` = 1 and the FSM stays in IDLE.
  - `en_denied` clears the cycle after loop or `full` drops.
  - `full` is sampled only in IDLE; a lane already past IDLE completes normally.
- **Motor outputs:** decoded from registered state.
  - `mot_open` = OPENING, `mot_close` = CLOSING, `gate_up` = WAIT_PASS or PASSING.
  - Open and close drives are never both 1.
- **Pulse arbiter:**
  - A count request produces a one-cycle pulse on the edge after the PASSING → CLOSING transition.
  - If entry and exit requests fall in the same cycle, `car_out` fires first and `car_in` is held in a pending flag and fires the next cycle.
  - A pending `car_in` also yields to any new exit request, so no pulse is ever lost.
- **Timers:** count down. "Expires" means the value is 1 on that edge.

## Timing
- **Reset values:** all outputs 0, both FSMs IDLE, timers 0, pending flag 0, filters 0.
- Reset asserted mid-sequence aborts immediately: motors off next edge, no pulse, pending request discarded.
- **Raw sensor → filtered:** `DEBOUNCE` edges.
- **Filtered → state change:** 1 edge.
- **Motor open duration:** exactly `OPEN_CYCLES` cycles; close duration exactly `CLOSE_CYCLES` cycles.
- **Beam-clear to pulse:** filtered beam 0 → state CLOSING on the next edge → `car_in`/`car_out` high for exactly 1 cycle on the edge after that (plus 1 if deferred).
- **Minimum gap between pulses from one lane:** `OPEN_CYCLES` + `CLOSE_CYCLES` + 2 cycles.

## Test plan
- **Entry pass, defaults:** `en_loop` high 10 cycles, then `en_beam` high 6 cycles then low.
  - `en_mot_open` high exactly 8 cycles; `en_gate_up` high until beam clears.
  - One `car_in` pulse; `en_mot_close` high 8 cycles; back to IDLE.
- **Full refusal:** `full` = 1, `en_loop` high 20 cycles → `en_denied` = 1 from cycle 6, no motor activity, no `car_in`. Dropping `full` → OPENING the following edge.
- **Timeout:** exit loop held, beam never broken → `ex_gate_up` for 64 cycles, then close, `car_out` never asserted.
- **Simultaneous:** both lanes driven so the beams clear on the same edge → `car_out` on cycle N, `car_in` on N+1, never both high.
- **Safety reversal:** entry beam rises 3 cycles into CLOSING → OPENING, 8-cycle open, then exactly one `car_in` after the final clear.
- **Glitch and reset:** beam glitch of 3 cycles ignored (no state change); reset pulsed during OPENING → all outputs 0 next edge, IDLE, no pulse.
